// File: rtl/gate_lane_pkg.sv
// rtl/gate_lane_pkg.sv - gate modes, gate evaluation and debounce counter sizing
package gate_lane_pkg;

    typedef enum logic [1:0] {
        MODE_OR   = 2'd0,
        MODE_AND  = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } gate_mode_e;

    // Counter must hold 0..DEB_CYCLES-1 without wrapping.
    function automatic int deb_cnt_w(input int deb_cycles);
        return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
    endfunction

    function automatic logic gate_eval(input gate_mode_e mode, input logic a, input logic b);
        logic r;
        case (mode)
            MODE_OR:   r = a | b;
            MODE_AND:  r = a & b;
            MODE_XOR:  r = a ^ b;
            MODE_NAND: r = ~(a & b);
            default:   r = a | b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_lane_debounce.sv
// rtl/gate_lane_debounce.sv - one lane: input synchronisers, debounce filter, output register, rise detect
module gate_lane_debounce
    import gate_lane_pkg::*;
#(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic raw,
    input  logic clr,
    output logic a_s,
    output logic b_s,
    output logic y,
    output logic rise,
    output logic rise_nxt
);

    localparam int DW = deb_cnt_w(DEB_CYCLES);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);

    logic          a_m;
    logic          b_m;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic          y_nxt;

    // A clear strobe (mode load) wins over any pending update, so y never moves on that edge.
    always_comb begin
        cnt_nxt = cnt;
        y_nxt   = y;
        if (clr) begin
            cnt_nxt = '0;
        end else if (raw == y) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            y_nxt   = raw;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        rise_nxt = y_nxt & ~y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_m  <= 1'b0;
            b_m  <= 1'b0;
            a_s  <= 1'b0;
            b_s  <= 1'b0;
            cnt  <= '0;
            y    <= 1'b0;
            rise <= 1'b0;
        end else begin
            a_m  <= a;
            b_m  <= b;
            a_s  <= a_m;
            b_s  <= b_m;
            cnt  <= cnt_nxt;
            y    <= y_nxt;
            rise <= rise_nxt;
        end
    end

endmodule

// File: rtl/gate_lane_array.sv
// rtl/gate_lane_array.sv - CHANNELS debounced two-input gates with shared mode register; event counter under GATE_LANE_EVT_CNT_EN
module gate_lane_array
    import gate_lane_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DEB_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a_i,
    input  logic [CHANNELS-1:0] b_i,
    input  logic [1:0]          mode_i,
    input  logic                mode_load_i,
    output logic [1:0]          mode_o,
    output logic [CHANNELS-1:0] y_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CNT_W-1:0]    evt_cnt_o
);

    gate_mode_e          mode_q;
    logic [CHANNELS-1:0] a_s;
    logic [CHANNELS-1:0] b_s;
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] rise_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_OR;
        end else if (mode_load_i) begin
            mode_q <= gate_mode_e'(mode_i);
        end
    end

    assign mode_o = mode_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign raw[c] = gate_eval(mode_q, a_s[c], b_s[c]);

        gate_lane_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .a        (a_i[c]),
            .b        (b_i[c]),
            .raw      (raw[c]),
            .clr      (mode_load_i),
            .a_s      (a_s[c]),
            .b_s      (b_s[c]),
            .y        (y_o[c]),
            .rise     (rise_o[c]),
            .rise_nxt (rise_nxt[c])
        );
    end

`ifdef GATE_LANE_EVT_CNT_EN
    // Headroom for up to 8 simultaneous rises on top of a full counter.
    localparam int SUM_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] EVT_MAX = '1;

    logic [CNT_W-1:0] evt_q;
    logic [SUM_W-1:0] rise_pop;
    logic [SUM_W-1:0] evt_sum;
    logic [CNT_W-1:0] evt_nxt;

    always_comb begin
        rise_pop = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rise_pop = rise_pop + SUM_W'(rise_nxt[c]);
        end
        evt_sum = SUM_W'(evt_q) + rise_pop;
        evt_nxt = (evt_sum > SUM_W'(EVT_MAX)) ? EVT_MAX : evt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_nxt;
        end
    end

    assign evt_cnt_o = evt_q;
`else
    logic unused_rise_nxt;
    assign unused_rise_nxt = ^rise_nxt;
    assign evt_cnt_o       = '0;
`endif

endmodule
